// File: rtl/line_tap_buffer.sv
// Multi-line delay buffer: chained line stores emit one vertical tap column per accepted pixel.
// Slice 0 of O_taps is the current pixel, slice k the same column k lines above.
module line_tap_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_LEN    = 2048,
  parameter int NUM_LINES  = 2
) (
  input  logic                                I_CLK,
  input  logic                                I_Rst,
  input  logic                                I_Sof,
  input  logic [ADDR_WIDTH:0]                 I_Line_Len,
  input  logic                                I_Valid,
  input  logic [DATA_WIDTH-1:0]               I_din,
  output logic                                O_Valid,
  output logic [DATA_WIDTH*(NUM_LINES+1)-1:0] O_taps,
  output logic [ADDR_WIDTH-1:0]               O_Col,
  output logic [3:0]                          O_Line_Cnt,
  output logic                                O_Lines_Ready,
  output logic                                O_Len_Err
);

  localparam int TAP_W = DATA_WIDTH * (NUM_LINES + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [ADDR_WIDTH:0] MAX_LEN_C = (ADDR_WIDTH + 1)'(MAX_LEN);
  localparam logic [3:0] NUM_LINES_C = 4'(NUM_LINES);

  logic [ADDR_WIDTH-1:0] col_r;
  logic [3:0]            line_cnt_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic                  len_err_r;
  logic                  valid_r;
  logic [TAP_W-1:0]      taps_r;
  logic [ADDR_WIDTH-1:0] ocol_r;
  logic                  ready_r;

  logic [ADDR_WIDTH-1:0] col_eff_s;
  logic [3:0]            cnt_eff_s;
  logic [ADDR_WIDTH:0]   len_eff_s;
  logic                  len_err_next_s;
  logic                  wrap_s;
  logic [ADDR_WIDTH-1:0] col_next_s;
  logic [3:0]            cnt_next_s;
  logic [TAP_W-1:0]      taps_s;
  logic [IDX_W-1:0]      addr_s;
  logic [DATA_WIDTH-1:0] chain_s [NUM_LINES+1];

  // Frame state as seen by this cycle's pixel: a same-cycle Sof takes effect first
  always_comb begin
    col_eff_s      = col_r;
    cnt_eff_s      = line_cnt_r;
    len_eff_s      = len_r;
    len_err_next_s = len_err_r;
    if (I_Sof) begin
      col_eff_s = '0;
      cnt_eff_s = 4'd0;
      if ((I_Line_Len == '0) || (I_Line_Len > MAX_LEN_C)) begin
        len_eff_s      = MAX_LEN_C;
        len_err_next_s = 1'b1;
      end else begin
        len_eff_s      = I_Line_Len;
        len_err_next_s = 1'b0;
      end
    end else begin
      len_eff_s = len_r;
    end
  end

  assign addr_s = col_eff_s[IDX_W-1:0];
  assign wrap_s = ({1'b0, col_eff_s} == (len_eff_s - (ADDR_WIDTH + 1)'(1)));

  // Column / line advance; blanking cycles leave the position frozen
  always_comb begin
    col_next_s = col_eff_s;
    cnt_next_s = cnt_eff_s;
    if (I_Valid) begin
      if (wrap_s) begin
        col_next_s = '0;
        if (cnt_eff_s < NUM_LINES_C) begin
          cnt_next_s = cnt_eff_s + 4'd1;
        end else begin
          cnt_next_s = cnt_eff_s;
        end
      end else begin
        col_next_s = col_eff_s + ADDR_WIDTH'(1);
      end
    end else begin
      col_next_s = col_eff_s;
    end
  end

  assign chain_s[0] = I_din;

  // Store g holds the line g+1 above; it reads before being overwritten with store g-1's old word
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_store
    logic [DATA_WIDTH-1:0] mem_r [MAX_LEN];

    assign chain_s[g+1] = mem_r[addr_s];

    // Line store write: shift the column down the chain
    always_ff @(posedge I_CLK) begin
      if (I_Valid && !I_Rst) begin
        mem_r[addr_s] <= chain_s[g];
      end
    end
  end

  // Mask slices whose store has not yet been filled in this frame
  always_comb begin
    taps_s = '0;
    for (int k = 0; k <= NUM_LINES; k++) begin
      if ((k == 0) || (cnt_eff_s >= 4'(k))) begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = chain_s[k];
      end else begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Frame state and registered outputs
  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      col_r      <= '0;
      line_cnt_r <= 4'd0;
      len_r      <= MAX_LEN_C;
      len_err_r  <= 1'b0;
      valid_r    <= 1'b0;
      taps_r     <= '0;
      ocol_r     <= '0;
      ready_r    <= 1'b0;
    end else begin
      col_r      <= col_next_s;
      line_cnt_r <= cnt_next_s;
      len_r      <= len_eff_s;
      len_err_r  <= len_err_next_s;
      valid_r    <= I_Valid;
      ready_r    <= (cnt_next_s == NUM_LINES_C);
      if (I_Valid) begin
        taps_r <= taps_s;
        ocol_r <= col_eff_s;
      end
    end
  end

  assign O_Valid       = valid_r;
  assign O_taps        = taps_r;
  assign O_Col         = ocol_r;
  assign O_Line_Cnt    = line_cnt_r;
  assign O_Lines_Ready = ready_r;
  assign O_Len_Err     = len_err_r;

endmodule

// File: tb/tb_line_tap_buffer.sv
// Directed bench for line_tap_buffer with a line-history reference model and expected-tap queue.
module tb_line_tap_buffer;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int ML = 2048;
  localparam int NL = 2;

  logic              I_CLK = 1'b0;
  logic              I_Rst = 1'b0;
  logic              I_Sof = 1'b0;
  logic [AW:0]       I_Line_Len = '0;
  logic              I_Valid = 1'b0;
  logic [DW-1:0]     I_din = '0;
  logic              O_Valid;
  logic [DW*3-1:0]   O_taps;
  logic [AW-1:0]     O_Col;
  logic [3:0]        O_Line_Cnt;
  logic              O_Lines_Ready;
  logic              O_Len_Err;

  line_tap_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN(ML), .NUM_LINES(NL)) dut (
    .I_CLK(I_CLK), .I_Rst(I_Rst), .I_Sof(I_Sof), .I_Line_Len(I_Line_Len),
    .I_Valid(I_Valid), .I_din(I_din), .O_Valid(O_Valid), .O_taps(O_taps),
    .O_Col(O_Col), .O_Line_Cnt(O_Line_Cnt), .O_Lines_Ready(O_Lines_Ready),
    .O_Len_Err(O_Len_Err)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct packed {
    logic [23:0] taps;
    logic [11:0] col;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  pix [int];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_col = 0, m_line = 0, m_cnt = 0, m_len = ML;
  logic        m_err = 1'b0;
  logic [23:0] last_taps = '0;
  logic [11:0] last_col = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model after the active edge
  task automatic check_outputs(input logic v);
    exp_t e;
    chk("valid", 32'(O_Valid), 32'(v));
    if (v) begin
      chk("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("taps", 32'(O_taps), 32'(e.taps));
        chk("col", 32'(O_Col), 32'(e.col));
        last_taps = e.taps;
        last_col  = e.col;
      end
    end else begin
      chk("hold_taps", 32'(O_taps), 32'(last_taps));
      chk("hold_col", 32'(O_Col), 32'(last_col));
    end
    chk("line_cnt", 32'(O_Line_Cnt), 32'(m_cnt));
    chk("lines_ready", 32'(O_Lines_Ready), 32'(m_cnt == NL));
    chk("len_err", 32'(O_Len_Err), 32'(m_err));
  endtask

  task automatic step(input logic v, input logic sof, input logic [AW:0] llen, input logic [7:0] d);
    exp_t e;
    @(negedge I_CLK);
    I_Valid = v; I_Sof = sof; I_Line_Len = llen; I_din = d; I_Rst = 1'b0;
    if (sof) begin
      m_col = 0; m_line = 0; m_cnt = 0;
      pix.delete();
      if ((llen == 0) || (int'(llen) > ML)) begin
        m_len = ML; m_err = 1'b1;
      end else begin
        m_len = int'(llen); m_err = 1'b0;
      end
    end
    if (v) begin
      e.taps = '0;
      e.taps[7:0] = d;
      for (int k = 1; k <= NL; k++) begin
        if (m_line >= k) e.taps[k*8 +: 8] = pix[(m_line - k) * 4096 + m_col];
      end
      e.col = 12'(m_col);
      sb_q.push_back(e);
      pix[m_line * 4096 + m_col] = d;
      if (m_col == m_len - 1) begin
        m_col = 0;
        m_line++;
        if (m_cnt < NL) m_cnt++;
      end else begin
        m_col++;
      end
    end
    @(posedge I_CLK);
    #1;
    check_outputs(v);
  endtask

  task automatic rst_step(input logic v);
    @(negedge I_CLK);
    I_Rst = 1'b1; I_Valid = v; I_Sof = 1'b0; I_din = 8'hEE;
    m_col = 0; m_line = 0; m_cnt = 0; m_len = ML; m_err = 1'b0;
    pix.delete();
    sb_q.delete();
    last_taps = '0; last_col = '0;
    @(posedge I_CLK);
    #1;
    check_outputs(1'b0);
    chk("rst_taps_zero", 32'(O_taps), 32'd0);
  endtask

  initial begin
    // Reset state
    rst_step(1'b0);
    step(1'b0, 1'b0, 13'd0, 8'd0);

    // Test 1: len=4, pixels 0..11
    step(1'b0, 1'b1, 13'd4, 8'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 13'd0, 8'(i));
      if (i == 8) begin
        chk("t1_px8_taps", 32'(O_taps), 32'h000408);
        chk("t1_px8_col", 32'(O_Col), 32'd0);
        chk("t1_px8_ready", 32'(O_Lines_Ready), 32'd1);
      end
    end

    // Test 2: single-cycle valid pulse
    step(1'b0, 1'b0, 13'd0, 8'd0);
    step(1'b1, 1'b0, 13'd0, 8'h55);
    step(1'b0, 1'b0, 13'd0, 8'd0);
    step(1'b0, 1'b0, 13'd0, 8'd0);

    // Test 4: Sof with Valid at line 1, column 2
    step(1'b0, 1'b1, 13'd4, 8'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 13'd0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 13'd4, 8'hAA);
    chk("t4_col", 32'(O_Col), 32'd0);
    chk("t4_cnt", 32'(O_Line_Cnt), 32'd0);
    chk("t4_upper", 32'(O_taps[23:8]), 32'd0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 13'd0, 8'(8'h30 + i));

    // Test 3: full-length lines with wrap and saturation
    step(1'b0, 1'b1, 13'd2048, 8'd0);
    for (int i = 0; i < 3 * ML + 5; i++) begin
      step(1'b1, 1'b0, 13'd0, 8'(i ^ (i >> 8)));
      if (i == 2047) chk("t3_last_col", 32'(O_Col), 32'd2047);
      if (i == 2048) chk("t3_wrap_col", 32'(O_Col), 32'd0);
      if (i == 3 * ML + 4) chk("t3_sat_cnt", 32'(O_Line_Cnt), 32'd2);
    end

    // Test 5: illegal lengths fall back to MAX_LEN
    step(1'b0, 1'b1, 13'd0, 8'd0);
    chk("t5_err0", 32'(O_Len_Err), 32'd1);
    for (int i = 0; i < ML + 2; i++) step(1'b1, 1'b0, 13'd0, 8'(i * 3));
    step(1'b0, 1'b1, 13'd4000, 8'd0);
    chk("t5_err4000", 32'(O_Len_Err), 32'd1);
    step(1'b0, 1'b1, 13'd2049, 8'd0);
    step(1'b1, 1'b0, 13'd0, 8'h11);
    step(1'b0, 1'b1, 13'd8, 8'd0);
    chk("t5_err_clr", 32'(O_Len_Err), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 13'd0, 8'(8'h80 + i));

    // Test 6: reset mid-line 2 while pixels arrive
    step(1'b0, 1'b1, 13'd4, 8'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 13'd0, 8'(8'h40 + i));
    rst_step(1'b1);
    chk("t6_col", 32'(O_Col), 32'd0);
    chk("t6_cnt", 32'(O_Line_Cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 13'd0, 8'(8'h60 + i));
      chk("t6_upper", 32'(O_taps[23:8]), 32'd0);
    end
    step(1'b0, 1'b0, 13'd0, 8'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
